ctrl_hazard_scoreboard: RTL and testbench

Parametrised decode-side control block for the pipelined MIPS core. It sits in the D stage beside the instruction decoder. It classifies the D-stage instruction by operand-use time (Tuse) and result-ready time (Tnew), and keeps a shift-register scoreboard of pending register writes for STAGES downstream stages. From that state it produces the pipeline stall, D-stage forward selects and a multiply/divide busy interlock. This replaces hand-written per-stage hazard comparisons with a depth-generic structure.

---
 rtl/ctrl_pkg.sv | 82 ++++++++
 rtl/ctrl_hazard_class.sv | 140 ++++++++++++++
 rtl/ctrl_hazard_scoreboard.sv | 104 ++++++++++
 tb/tb_ctrl_hazard_scoreboard.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared decode constants and scoreboard entry type for the MIPS control path.
// Pure declarations; no logic or latency.
package ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2a;
  localparam logic [5:0] F_SLTU  = 6'h2b;
  localparam logic [5:0] F_ERET  = 6'h18;

  localparam logic [4:0] C0_MF = 5'h00;
  localparam logic [4:0] C0_MT = 5'h04;
  localparam logic [4:0] C0_CO = 5'h10;

  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_M    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic [1:0] tnew;
  } sb_entry_t;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/ctrl_hazard_class.sv
// Combinational instruction classifier: sources, Tuse, destination, Tnew, MDU use, RI.
// Zero latency; unsupported encodings report ri_exc_o with all uses/writes cleared.
module ctrl_hazard_class
  import ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [4:0]  src_rs_o,
  output logic [4:0]  src_rt_o,
  output logic [1:0]  tuse_rs_o,
  output logic [1:0]  tuse_rt_o,
  output logic [4:0]  dst_o,
  output logic [1:0]  tnew_o,
  output logic        is_md_o,
  output logic        md_start_o,
  output logic        md_div_o,
  output logic        ri_exc_o
);

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, sh;

  assign op = instr_i[31:26];
  assign rs = instr_i[25:21];
  assign rt = instr_i[20:16];
  assign rd = instr_i[15:11];
  assign sh = instr_i[10:6];
  assign fn = instr_i[5:0];

  assign src_rs_o = rs;
  assign src_rt_o = rt;

  always_comb begin
    tuse_rs_o  = TUSE_NONE;
    tuse_rt_o  = TUSE_NONE;
    dst_o      = 5'd0;
    tnew_o     = TNEW_LINK;
    is_md_o    = 1'b0;
    md_start_o = 1'b0;
    md_div_o   = 1'b0;
    ri_exc_o   = 1'b0;
    case (op)
      OP_SPECIAL: begin
        // Non-shift R-type encodings must carry a zero shamt field.
        ri_exc_o = (sh != 5'd0);
        case (fn)
          F_SLL, F_SRL, F_SRA: begin
            ri_exc_o  = (rs != 5'd0);
            tuse_rt_o = TUSE_E;
            dst_o     = rd;
            tnew_o    = TNEW_ALU;
          end
          F_SLLV, F_SRLV, F_SRAV, F_ADD, F_ADDU, F_SUB, F_SUBU,
          F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
            tuse_rs_o = TUSE_E;
            tuse_rt_o = TUSE_E;
            dst_o     = rd;
            tnew_o    = TNEW_ALU;
          end
          F_JR:   tuse_rs_o = TUSE_D;
          F_JALR: begin
            tuse_rs_o = TUSE_D;
            dst_o     = rd;
            tnew_o    = TNEW_LINK;
          end
          F_MFHI, F_MFLO: begin
            dst_o   = rd;
            tnew_o  = TNEW_ALU;
            is_md_o = 1'b1;
          end
          F_MTHI, F_MTLO: begin
            tuse_rs_o = TUSE_E;
            is_md_o   = 1'b1;
          end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            tuse_rs_o  = TUSE_E;
            tuse_rt_o  = TUSE_E;
            is_md_o    = 1'b1;
            md_start_o = 1'b1;
            md_div_o   = (fn == F_DIV) || (fn == F_DIVU);
          end
          default: ri_exc_o = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        if (rt == 5'd0 || rt == 5'd1) tuse_rs_o = TUSE_D;
        else ri_exc_o = 1'b1;
      end
      OP_J: ;
      OP_JAL: begin
        dst_o  = 5'd31;
        tnew_o = TNEW_LINK;
      end
      OP_BEQ, OP_BNE: begin
        tuse_rs_o = TUSE_D;
        tuse_rt_o = TUSE_D;
      end
      OP_BLEZ, OP_BGTZ: tuse_rs_o = TUSE_D;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        tuse_rs_o = TUSE_E;
        dst_o     = rt;
        tnew_o    = TNEW_ALU;
      end
      OP_LUI: begin
        dst_o  = rt;
        tnew_o = TNEW_ALU;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        tuse_rs_o = TUSE_E;
        dst_o     = rt;
        tnew_o    = TNEW_LOAD;
      end
      OP_SB, OP_SH, OP_SW: begin
        tuse_rs_o = TUSE_E;
        tuse_rt_o = TUSE_M;
      end
      OP_COP0: begin
        case (rs)
          C0_MF: begin
            dst_o  = rt;
            tnew_o = TNEW_LOAD;
          end
          C0_MT:   tuse_rt_o = TUSE_M;
          C0_CO:   ri_exc_o = (fn != F_ERET);
          default: ri_exc_o = 1'b1;
        endcase
      end
      default: ri_exc_o = 1'b1;
    endcase
    if (ri_exc_o) begin
      tuse_rs_o  = TUSE_NONE;
      tuse_rt_o  = TUSE_NONE;
      dst_o      = 5'd0;
      tnew_o     = TNEW_LINK;
      is_md_o    = 1'b0;
      md_start_o = 1'b0;
      md_div_o   = 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_hazard_scoreboard.sv
// D-stage hazard control: pending-write scoreboard, stall, D-stage forward selects, MDU interlock.
// Outputs are combinational from instr_D and registered state; state advances on clk.
module ctrl_hazard_scoreboard
  import ctrl_pkg::*;
#(
  parameter int STAGES      = 3,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  localparam int CNT_W      = $clog2(DIV_CYCLES + 1),
  localparam int SEL_W      = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_D,
  input  logic             valid_D,
  input  logic             flush,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_rs_sel,
  output logic [SEL_W-1:0] fwd_rt_sel,
  output logic             md_busy,
  output logic             ri_exc
);

  logic [4:0] src_rs, src_rt, cls_dst;
  logic [1:0] tuse_rs, tuse_rt, cls_tnew;
  logic       cls_md, cls_md_start, cls_md_div, cls_ri;

  ctrl_hazard_class u_class (
    .instr_i    (instr_D),
    .src_rs_o   (src_rs),
    .src_rt_o   (src_rt),
    .tuse_rs_o  (tuse_rs),
    .tuse_rt_o  (tuse_rt),
    .dst_o      (cls_dst),
    .tnew_o     (cls_tnew),
    .is_md_o    (cls_md),
    .md_start_o (cls_md_start),
    .md_div_o   (cls_md_div),
    .ri_exc_o   (cls_ri)
  );

  sb_entry_t        sb_q [1:STAGES];
  sb_entry_t        sb_d [1:STAGES];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STAGES:1]  raw_vec, rs_fwd_vec, rt_fwd_vec;
  logic             md_hazard, md_load;

  for (genvar k = 1; k <= STAGES; k++) begin : g_cmp
    logic live, rs_hit, rt_hit;
    assign live   = sb_q[k].v && (sb_q[k].dst != 5'd0);
    assign rs_hit = live && (sb_q[k].dst == src_rs);
    assign rt_hit = live && (sb_q[k].dst == src_rt);
    assign raw_vec[k]    = (rs_hit && (sb_q[k].tnew > tuse_rs)) ||
                           (rt_hit && (sb_q[k].tnew > tuse_rt));
    assign rs_fwd_vec[k] = rs_hit && (sb_q[k].tnew == 2'd0);
    assign rt_fwd_vec[k] = rt_hit && (sb_q[k].tnew == 2'd0);
  end

  // Scan deepest-first so the youngest matching stage overwrites the select.
  always_comb begin
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    for (int i = STAGES; i >= 1; i--) begin
      if (rs_fwd_vec[i]) fwd_rs_sel = SEL_W'(i);
      if (rt_fwd_vec[i]) fwd_rt_sel = SEL_W'(i);
    end
  end

  assign md_hazard = cls_md && (cnt_q != '0);
  assign stall     = valid_D && ((|raw_vec) || md_hazard);
  assign ri_exc    = valid_D && cls_ri;
  assign md_busy   = (cnt_q != '0);
  assign md_load   = valid_D && !stall && !flush && cls_md_start;

  always_comb begin
    sb_d[1].v    = valid_D && !cls_ri && !stall;
    sb_d[1].dst  = cls_dst;
    sb_d[1].tnew = cls_tnew;
    for (int i = 2; i <= STAGES; i++) begin
      sb_d[i]      = sb_q[i-1];
      sb_d[i].tnew = tnew_dec(sb_q[i-1].tnew);
    end
    if (flush) begin
      for (int i = 1; i <= STAGES; i++) sb_d[i].v = 1'b0;
    end
  end

  always_comb begin
    if (md_load)             cnt_d = cls_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (cnt_q != '0)    cnt_d = cnt_q - CNT_W'(1);
    else                     cnt_d = cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i <= STAGES; i++) sb_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 1; i <= STAGES; i++) sb_q[i] <= sb_d[i];
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ctrl_hazard_scoreboard.sv
// Directed bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_ctrl_hazard_scoreboard;

  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      instr_D = 32'h0;
  logic             valid_D = 1'b0;
  logic             flush = 1'b0;
  logic             stall;
  logic [SEL_W-1:0] fwd_rs_sel, fwd_rt_sel;
  logic             md_busy, ri_exc;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic       st;
    logic [1:0] rs;
    logic [1:0] rt;
    logic       busy;
    logic       ri;
  } exp_t;

  exp_t exp_q[$];

  ctrl_hazard_scoreboard #(.STAGES(3), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_D    (instr_D),
    .valid_D    (valid_D),
    .flush      (flush),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .md_busy    (md_busy),
    .ri_exc     (ri_exc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 16'h0000};
  endfunction

  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%0h expected=%0h", n, f, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(e.name, "stall", {31'd0, stall}, {31'd0, e.st});
      chk(e.name, "fwd_rs_sel", {30'd0, fwd_rs_sel}, {30'd0, e.rs});
      chk(e.name, "fwd_rt_sel", {30'd0, fwd_rt_sel}, {30'd0, e.rt});
      chk(e.name, "md_busy", {31'd0, md_busy}, {31'd0, e.busy});
      chk(e.name, "ri_exc", {31'd0, ri_exc}, {31'd0, e.ri});
    end
  end

  task automatic step(input string n, input logic [31:0] ins, input logic vld, input logic fl,
                      input logic rst, input logic e_st, input logic [1:0] e_rs,
                      input logic [1:0] e_rt, input logic e_busy, input logic e_ri);
    exp_t e;
    @(posedge clk);
    #1;
    instr_D = ins;
    valid_D = vld;
    flush   = fl;
    if (rst) begin
      #1 reset = 1'b1;
    end else begin
      reset = 1'b0;
    end
    e.name = n; e.st = e_st; e.rs = e_rs; e.rt = e_rt; e.busy = e_busy; e.ri = e_ri;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string n, input int cnt, input logic busy);
    for (int i = 0; i < cnt; i++) step(n, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, busy, 1'b0);
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [31:0] lw1, addu3, beq12, addu1, jr1, jr3, addu0, jr0, jal, jr31;
    logic [31:0] beq31, beq0_31, mult12, div12, mflo4, inv, jr5;
    lw1     = itype(6'h23, 0, 1);
    addu3   = rtype(1, 2, 3, 6'h21);
    beq12   = itype(6'h04, 1, 2);
    addu1   = rtype(2, 3, 1, 6'h21);
    jr1     = rtype(1, 0, 0, 6'h08);
    jr3     = rtype(3, 0, 0, 6'h08);
    addu0   = rtype(2, 3, 0, 6'h21);
    jr0     = rtype(0, 0, 0, 6'h08);
    jal     = {6'h03, 26'h0};
    jr31    = rtype(31, 0, 0, 6'h08);
    beq31   = itype(6'h04, 31, 31);
    beq0_31 = itype(6'h04, 0, 31);
    mult12  = rtype(1, 2, 0, 6'h18);
    div12   = rtype(1, 2, 0, 6'h1a);
    mflo4   = rtype(0, 0, 4, 6'h12);
    inv     = {6'h3F, 5'd0, 5'd5, 16'h0};
    jr5     = rtype(5, 0, 0, 6'h08);

    step("rst_idle", 32'h0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("rst_lw",   lw1,   1, 0, 1, 0, 0, 0, 0, 0);
    idle("post_rst", 1, 0);

    step("t1_lw",      lw1,   1, 0, 0, 0, 0, 0, 0, 0);
    step("t1_addu_st", addu3, 1, 0, 0, 1, 0, 0, 0, 0);
    step("t1_addu_go", addu3, 1, 0, 0, 0, 0, 0, 0, 0);
    step("t1_jr3_st",  jr3,   1, 0, 0, 1, 0, 0, 0, 0);
    step("t1_jr3_fwd", jr3,   1, 0, 0, 0, 2, 0, 0, 0);
    idle("t1_drain", 3, 0);

    step("t2_lw",       lw1,   1, 0, 0, 0, 0, 0, 0, 0);
    step("t2_beq_st1",  beq12, 1, 0, 0, 1, 0, 0, 0, 0);
    step("t2_beq_st2",  beq12, 1, 0, 0, 1, 0, 0, 0, 0);
    step("t2_beq_fwd",  beq12, 1, 0, 0, 0, 3, 0, 0, 0);
    idle("t2_drain", 3, 0);

    step("t3_addu1",   addu1, 1, 0, 0, 0, 0, 0, 0, 0);
    step("t3_jr1_st",  jr1,   1, 0, 0, 1, 0, 0, 0, 0);
    step("t3_jr1_fwd", jr1,   1, 0, 0, 0, 2, 0, 0, 0);
    idle("t3_drain", 3, 0);
    step("t3_addu0",   addu0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("t3_jr0",     jr0,   1, 0, 0, 0, 0, 0, 0, 0);
    idle("t3_drain0", 3, 0);

    step("t3_jal_a",   jal,     1, 0, 0, 0, 0, 0, 0, 0);
    step("t3_jal_b",   jal,     1, 0, 0, 0, 0, 0, 0, 0);
    step("t3_beq31",   beq31,   1, 0, 0, 0, 1, 1, 0, 0);
    step("t3_beq0_31", beq0_31, 1, 0, 0, 0, 0, 2, 0, 0);
    step("t3_jr31",    jr31,    1, 0, 0, 0, 3, 0, 0, 0);
    idle("t3_drain31", 3, 0);

    step("t4_mult", mult12, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("t4_mflo_st", mflo4, 1, 0, 0, 1, 0, 0, 1, 0);
    step("t4_mflo_go", mflo4, 1, 0, 0, 0, 0, 0, 0, 0);
    idle("t4_drain", 3, 0);
    step("t4_div", div12, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("t4_mflo_dst", mflo4, 1, 0, 0, 1, 0, 0, 1, 0);
    step("t4_mflo_dgo", mflo4, 1, 0, 0, 0, 0, 0, 0, 0);
    idle("t4_ddrain", 3, 0);

    step("t5_lw",        lw1,   1, 0, 0, 0, 0, 0, 0, 0);
    step("t5_flush",     addu3, 1, 1, 0, 1, 0, 0, 0, 0);
    step("t5_after",     addu3, 1, 0, 0, 0, 0, 0, 0, 0);
    idle("t5_drain", 3, 0);

    step("t6_div", div12, 1, 0, 0, 0, 0, 0, 0, 0);
    idle("t6_busy", 3, 1);
    step("t6_rst_mid", 32'h0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle("t6_post", 1, 0);

    step("t7_inv",      inv, 1, 0, 0, 0, 0, 0, 0, 1);
    step("t7_jr5",      jr5, 1, 0, 0, 0, 0, 0, 0, 0);
    step("t7_inv_bub",  inv, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("t7_end", 1, 0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
